// File: rtl/dmem_pkg.sv
// Shared dmem definitions: access width codes, arbiter states and the
// alignment/legality check used by dmem, the LSU and the arbiter.
package dmem_pkg;

  typedef enum logic [2:0] {
    W_LB  = 3'b000,
    W_LH  = 3'b001,
    W_LW  = 3'b010,
    W_LBU = 3'b100,
    W_LHU = 3'b101
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  function automatic logic is_legal_access(input logic       write,
                                           input logic [2:0] width,
                                           input logic [1:0] addr_lo);
    logic ok;
    case (width)
      W_LB:    ok = 1'b1;
      W_LH:    ok = !addr_lo[0];
      W_LW:    ok = (addr_lo == 2'b00);
      W_LBU:   ok = !write;
      W_LHU:   ok = !write && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way grant selection: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module dmem_arb_pick (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o,
  output logic       idx_o,
  output logic       any_o
);

  always_comb begin
    any_o   = |valid_i;
    idx_o   = valid_i[1] && (!valid_i[0] || !last_i);
    grant_o = '0;
    if (any_o) begin
      grant_o = idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between two requesters, one access in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][2:0]        req_width,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      write_data,
  output logic [2:0]             width,
  output logic                   read_enable,
  output logic                   write_enable,
  input  logic [DATA_W-1:0]      read_data
);

  state_e            state_q;
  logic              gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        width_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [1:0]        pick_gnt;
  logic              pick_idx;
  logic              pick_any;
  logic              last_gnt;
  logic              accept;
  logic              sel_write_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_wdata_d;
  logic [2:0]        sel_width_d;
  logic              legal_d;

  dmem_arb_pick u_pick (
    .valid_i (req_valid),
    .last_i  (last_gnt),
    .grant_o (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign accept      = (state_q == S_IDLE) && pick_any;
  assign req_ready   = (state_q == S_IDLE) ? pick_gnt : 2'b00;
  assign sel_write_d = req_write[pick_idx];
  assign sel_addr_d  = req_addr[pick_idx];
  assign sel_wdata_d = req_wdata[pick_idx];
  assign sel_width_d = req_width[pick_idx];
  assign legal_d     = is_legal_access(sel_write_d, sel_width_d, sel_addr_d[1:0]);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b1;
    end else if (accept) begin
      rr_q <= pick_idx;
    end
  end

  assign last_gnt = rr_q;
`else
  // Pinning "last granted" to 1 makes the picker's tie rule favour requester 0.
  assign last_gnt = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            gnt_q   <= pick_idx;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            width_q <= sel_width_d;
            if (legal_d) begin
              state_q <= S_ACCESS;
              rd_en_q <= !sel_write_d;
              wr_en_q <= sel_write_d;
            end else begin
              // Illegal requests skip dmem entirely and answer next cycle.
              state_q     <= S_RESP;
              rsp_valid_q <= pick_gnt;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        S_ACCESS: begin
          state_q     <= S_RESP;
          rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= rd_en_q ? read_data : '0;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign width        = width_q;
  assign read_enable  = rd_en_q;
  assign write_enable = wr_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized requests checked
// against a byte-array memory reference and the arbitration/legality rules.
module tb_dmem_arbiter;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][2:0]  req_width;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [31:0]      address;
  logic [31:0]      write_data;
  logic [2:0]       width;
  logic             read_enable;
  logic             write_enable;
  logic [31:0]      read_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_g = 1;
  logic [31:0] obs_rd;
  logic        obs_err;
  logic [7:0]  mem_dut [64];
  logic [7:0]  mem_ref [64];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_width    (req_width),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .address      (address),
    .write_data   (write_data),
    .width        (width),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .read_data    (read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory on the DUT side: combinational read, store at the clock edge.
  always_comb begin
    logic [5:0] a;
    logic [7:0] b0, b1, b2, b3;
    a  = address[5:0];
    b0 = mem_dut[a];
    b1 = mem_dut[a + 6'd1];
    b2 = mem_dut[a + 6'd2];
    b3 = mem_dut[a + 6'd3];
    case (width)
      3'b000:  read_data = {{24{b0[7]}}, b0};
      3'b001:  read_data = {{16{b1[7]}}, b1, b0};
      3'b100:  read_data = {24'd0, b0};
      3'b101:  read_data = {16'd0, b1, b0};
      default: read_data = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (write_enable) begin
      mem_dut[address[5:0]] <= write_data[7:0];
      if (width[1:0] != 2'b00) mem_dut[address[5:0] + 6'd1] <= write_data[15:8];
      if (width[1:0] == 2'b10) begin
        mem_dut[address[5:0] + 6'd2] <= write_data[23:16];
        mem_dut[address[5:0] + 6'd3] <= write_data[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] wd);
    return (wd[1:0] == 2'b00) ? 1 : (wd[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_legal(input logic w, input logic [2:0] wd, input logic [5:0] a);
    if (wd == 3'b011 || wd == 3'b110 || wd == 3'b111) return 1'b0;
    if (w && wd[2]) return 1'b0;
    return (int'(a) % nbytes(wd)) == 0;
  endfunction

  function automatic int exp_pick(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return (last_g == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [2:0] wd);
    logic [31:0] val;
    int n;
    n   = nbytes(wd);
    val = 0;
    for (int i = 0; i < n; i++) val = val + (32'(mem_ref[6'(int'(a) + i)]) << (8 * i));
    if (!wd[2] && n < 4 && val >= (32'd1 << (8 * n - 1))) val = val - (32'd1 << (8 * n));
    return val;
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [2:0] wd, input logic [31:0] d);
    for (int i = 0; i < nbytes(wd); i++) mem_ref[6'(int'(a) + i)] = 8'(d >> (8 * i));
  endtask

  task automatic setp(input int p, input logic w, input logic [5:0] a,
                      input logic [2:0] wd, input logic [31:0] d);
    req_write[p] = w;
    req_addr[p]  = 32'(a);
    req_width[p] = wd;
    req_wdata[p] = d;
  endtask

  // One request round: present v, check grant, then dmem cycle and response.
  task automatic step(input logic [1:0] v);
    int          g;
    logic        w;
    logic        legal;
    logic [5:0]  a;
    logic [2:0]  wd;
    logic [31:0] d;
    logic [31:0] exp_rd;
    @(negedge clk);
    req_valid = v;
    #1;
    g     = exp_pick(v);
    w     = req_write[g];
    a     = req_addr[g][5:0];
    wd    = req_width[g];
    d     = req_wdata[g];
    legal = exp_legal(w, wd, a);
    chk("ready", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    last_g = g;
    @(negedge clk);
    chk("busy_ready", 32'(req_ready), 32'd0);
    exp_rd = '0;
    if (legal) begin
      chk("rd_en", 32'(read_enable), 32'(!w));
      chk("wr_en", 32'(write_enable), 32'(w));
      chk("address", address, 32'(a));
      chk("width", 32'(width), 32'(wd));
      if (w) chk("wdata", write_data, d);
      chk("early_rsp", 32'(rsp_valid), 32'd0);
      if (w) ref_store(a, wd, d);
      else exp_rd = ref_load(a, wd);
      @(negedge clk);
    end
    chk("en_in_rsp", 32'({read_enable, write_enable}), 32'd0);
    chk("rsp_valid", 32'(rsp_valid), (g == 1) ? 32'd2 : 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(!legal));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    obs_rd  = rsp_rdata;
    obs_err = rsp_err;
  endtask

  initial begin
    logic [2:0] wtab [8];
    wtab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b001, 3'b000};
    for (int i = 0; i < 64; i++) begin
      mem_dut[i] = 8'($urandom);
      mem_ref[i] = mem_dut[i];
    end
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_width = '0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_en", 32'({read_enable, write_enable}), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_wdata", write_data, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_width", 32'(width), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    setp(0, 1'b1, 6'd4, 3'b010, 32'h0000_00F0);
    step(2'b01);
    setp(0, 1'b0, 6'd4, 3'b010, 32'd0);
    step(2'b01);
    chk("tp_sw_lw", obs_rd, 32'h0000_00F0);

    setp(1, 1'b1, 6'd4, 3'b010, 32'hA1B2_C3D4);
    step(2'b10);
    setp(1, 1'b0, 6'd5, 3'b100, 32'd0);
    step(2'b10);
    chk("tp_lbu", obs_rd, 32'h0000_00C3);

    setp(0, 1'b0, 6'd2, 3'b010, 32'd0);
    step(2'b01);
    chk("tp_mis_err", 32'(obs_err), 32'd1);

    for (int k = 0; k < 6; k++) begin
      setp(0, 1'b0, 6'($urandom_range(0, 15) * 4), 3'b010, 32'd0);
      setp(1, 1'b0, 6'($urandom_range(0, 15) * 4), 3'b010, 32'd0);
      step(2'b11);
    end

    setp(1, 1'b1, 6'd8, 3'b100, 32'hDEAD_BEEF);
    step(2'b10);
    setp(1, 1'b0, 6'd8, 3'b010, 32'd0);
    step(2'b10);

    setp(0, 1'b0, 6'd16, 3'b010, 32'd0);
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    #2;
    chk("pre_rst_rd_en", 32'(read_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_en", 32'({read_enable, write_enable}), 32'd0);
    chk("mid_rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("mid_rst_addr", address, 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    last_g = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst = 1'b0;
    step(2'b01);

    for (int k = 0; k < 60; k++) begin
      for (int p = 0; p < 2; p++) begin
        logic [5:0] a;
        logic [2:0] wd;
        a  = 6'($urandom_range(0, 63));
        wd = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : wtab[$urandom_range(0, 7)];
        if ($urandom_range(0, 2) != 0) a = a & 6'h3C;
        setp(p, 1'($urandom_range(0, 1)), a, wd, $urandom);
      end
      step(2'($urandom_range(1, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
